// File: rtl/jk_pkg.sv
// Shared JK command encodings and the same-cycle press merge rule.
// Used by the command debouncer and by the flip-flop bench.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Set and clear together collapse to a toggle, as does any toggle press.
    function automatic logic [1:0] jk_merge(input logic p_set, input logic p_clr,
                                            input logic p_tog);
        if (p_tog || (p_set && p_clr)) begin
            return JK_TOGGLE;
        end else if (p_set) begin
            return JK_SET;
        end else if (p_clr) begin
            return JK_RESET;
        end else begin
            return JK_HOLD;
        end
    endfunction

endpackage

// File: rtl/jk_debounce_ch.sv
// One button channel: 2-flop synchronizer, counting debouncer and
// a single-cycle pulse on each debounced rising edge.
module jk_debounce_ch #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic press
);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= raw_in;
            s2       <= s1;
            stable_q <= stable;
            // Any return to the stable value throws away the partial count.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = stable & ~stable_q;

endmodule

// File: rtl/jk_cmd_debouncer.sv
// Three debounced buttons merged into registered one-cycle J/K commands,
// with a wrapping count of issued commands.
module jk_cmd_debouncer
    import jk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_set,
    input  logic       btn_clr,
    input  logic       btn_tog,
    output logic       J,
    output logic       K,
    output logic [7:0] cmd_cnt
);

    logic       p_set;
    logic       p_clr;
    logic       p_tog;
    logic [1:0] cmd;

    jk_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_set (
        .clk   (clk),
        .rst   (rst),
        .raw_in(btn_set),
        .press (p_set)
    );

    jk_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clr (
        .clk   (clk),
        .rst   (rst),
        .raw_in(btn_clr),
        .press (p_clr)
    );

    jk_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_tog (
        .clk   (clk),
        .rst   (rst),
        .raw_in(btn_tog),
        .press (p_tog)
    );

    assign cmd = jk_merge(p_set, p_clr, p_tog);

    // Press pulses are one cycle wide, so the registered command is too.
    always_ff @(posedge clk) begin
        if (rst) begin
            J       <= 1'b0;
            K       <= 1'b0;
            cmd_cnt <= 8'd0;
        end else begin
            J <= cmd[1];
            K <= cmd[0];
            if (cmd != JK_HOLD) begin
                cmd_cnt <= cmd_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_debouncer.sv
// Bench for jk_cmd_debouncer with DEBOUNCE_CYCLES = 4: table of button
// vectors plus hand sequences, checked against a queue of expected commands.
module tb_jk_cmd_debouncer;
    import jk_pkg::*;

    localparam int unsigned D    = 4;
    localparam int unsigned IDLE = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_set = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_tog = 1'b0;
    logic       J;
    logic       K;
    logic [7:0] cmd_cnt;

    jk_cmd_debouncer #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_set(btn_set),
        .btn_clr(btn_clr),
        .btn_tog(btn_tog),
        .J      (J),
        .K      (K),
        .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [1:0]  jk;
    } exp_t;

    typedef struct {
        logic        s;
        logic        c;
        logic        t;
        int unsigned hold;
        logic [1:0]  jk;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[9];
    int unsigned cyc = 0;
    int unsigned nvec = 0;
    int unsigned nerr = 0;
    logic [7:0]  exp_cnt = 8'd0;

    // Compare at each sample against the oldest pending expectation.
    task automatic check_outputs();
        logic [1:0] jk;
        exp_t       e;
        jk = {J, K};
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            exp_cnt = exp_cnt + 8'd1;
            nvec++;
            if (jk !== e.jk) begin
                nerr++;
                $display("FAIL jk_cmd cyc=%0d got=%b want=%b", cyc, jk, e.jk);
            end
            nvec++;
            if (cmd_cnt !== exp_cnt) begin
                nerr++;
                $display("FAIL cmd_cnt cyc=%0d got=%0d want=%0d", cyc, cmd_cnt, exp_cnt);
            end
        end else if (jk !== JK_HOLD) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_cmd cyc=%0d got=%b want=00", cyc, jk);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic expect_cmd(input int unsigned due, input logic [1:0] jk);
        exp_t e;
        e.due = due;
        e.jk  = jk;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string name);
        nvec++;
        if ({J, K, cmd_cnt} !== 10'd0) begin
            nerr++;
            $display("FAIL %s got J=%b K=%b cnt=%0d want J=0 K=0 cnt=0", name, J, K, cmd_cnt);
        end
    endtask

    task automatic apply_rst(input int unsigned n);
        rst = 1'b1;
        exp_cnt = 8'd0;
        repeat (n) tick();
        check_reset_state("reset_state");
        rst = 1'b0;
    endtask

    // Buttons go high together now; first sampling edge is cyc+1.
    task automatic press(input logic s, input logic c, input logic t,
                         input int unsigned hold, input logic [1:0] jk);
        btn_set = s;
        btn_clr = c;
        btn_tog = t;
        if (jk != JK_HOLD) expect_cmd(cyc + 3 + D, jk);
        repeat (hold) tick();
        btn_set = 1'b0;
        btn_clr = 1'b0;
        btn_tog = 1'b0;
        repeat (IDLE) tick();
    endtask

    initial begin
        vecs[0] = '{s: 1'b1, c: 1'b0, t: 1'b0, hold: 4, jk: JK_SET};
        vecs[1] = '{s: 1'b0, c: 1'b1, t: 1'b0, hold: 6, jk: JK_RESET};
        vecs[2] = '{s: 1'b0, c: 1'b0, t: 1'b1, hold: 5, jk: JK_TOGGLE};
        vecs[3] = '{s: 1'b1, c: 1'b1, t: 1'b0, hold: 6, jk: JK_TOGGLE};
        vecs[4] = '{s: 1'b1, c: 1'b0, t: 1'b1, hold: 6, jk: JK_TOGGLE};
        vecs[5] = '{s: 1'b1, c: 1'b1, t: 1'b1, hold: 6, jk: JK_TOGGLE};
        vecs[6] = '{s: 1'b0, c: 1'b1, t: 1'b1, hold: 6, jk: JK_TOGGLE};
        vecs[7] = '{s: 1'b1, c: 1'b0, t: 1'b0, hold: 3, jk: JK_HOLD};
        vecs[8] = '{s: 1'b0, c: 1'b1, t: 1'b0, hold: 1, jk: JK_HOLD};

        // Reset with all buttons low.
        apply_rst(3);
        repeat (4) tick();

        // Reset lands while the set debounce count is in flight.
        btn_set = 1'b1;
        repeat (4) tick();
        btn_set = 1'b0;
        apply_rst(2);
        repeat (IDLE) tick();
        check_reset_state("mid_count_reset");

        // Clean set press at minimum hold, then release with no command.
        press(1'b1, 1'b0, 1'b0, 4, JK_SET);
        nvec++;
        if (cmd_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL first_press_cnt got=%0d want=1", cmd_cnt);
        end

        for (int i = 0; i < 9; i++) begin
            press(vecs[i].s, vecs[i].c, vecs[i].t, vecs[i].hold, vecs[i].jk);
        end

        // Bounce: 3-cycle highs are rejected, then a 6-cycle hold is accepted.
        for (int r = 0; r < 2; r++) begin
            btn_clr = 1'b1;
            repeat (3) tick();
            btn_clr = 1'b0;
            tick();
        end
        press(1'b0, 1'b1, 1'b0, 6, JK_RESET);

        // Skew: set one cycle ahead of clear gives two separate commands.
        btn_set = 1'b1;
        expect_cmd(cyc + 3 + D, JK_SET);
        tick();
        btn_clr = 1'b1;
        expect_cmd(cyc + 3 + D, JK_RESET);
        repeat (5) tick();
        btn_set = 1'b0;
        tick();
        btn_clr = 1'b0;
        repeat (IDLE) tick();

        // 256 toggles wrap the counter back to zero.
        apply_rst(1);
        for (int n = 0; n < 256; n++) begin
            btn_tog = 1'b1;
            expect_cmd(cyc + 3 + D, JK_TOGGLE);
            repeat (4) tick();
            btn_tog = 1'b0;
            repeat (6) tick();
        end
        repeat (IDLE) tick();
        nvec++;
        if (cmd_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL wrap_cnt got=%0d want=0", cmd_cnt);
        end

        // Toggle held across reset presses again after the full latency.
        btn_tog = 1'b1;
        expect_cmd(cyc + 3 + D, JK_TOGGLE);
        repeat (10) tick();
        apply_rst(2);
        expect_cmd(cyc + 3 + D, JK_TOGGLE);
        repeat (IDLE) tick();
        btn_tog = 1'b0;
        repeat (IDLE) tick();

        nvec++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL pending_cmds got=%0d want=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
